if_id_pipe_reg: RTL

Parametrised IF/ID pipeline register, replacing the fixed 32-bit, always-advance register between the fetch and decode stages. It carries instruction, PC and a misalignment flag, and adds a valid/ready handshake in both directions. It supports stall (back-pressure from decode), flush (branch/jump redirect) and NOP bubble insertion. A compile-time option selects a 2-entry skid buffer so that `in_ready` is driven directly from a register.

---
 rtl/if_id_pipe_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a valid/ready handshake on both sides, plus flush and NOP bubbles.
// Define IF_ID_SKID_EN to get a 2-entry skid buffer that drives in_ready straight from a flop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | nothing held; decode sees a NOP bubble
//   ST_ONE   | head entry valid
//   ST_FULL  | head and second entry valid; fetch is stalled (skid only)

module if_id_pipe_reg #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_misalign
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ILEN-1:0] head_instr_q;
  logic [XLEN-1:0] head_pc_q;
  logic            push, pop;
  logic            load_head;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

`ifdef IF_ID_SKID_EN
  logic [ILEN-1:0] tail_instr_q;
  logic [XLEN-1:0] tail_pc_q;
  logic            load_tail;
  logic            shift;
  logic            in_ready_q;

  assign in_ready = in_ready_q;
`else
  // Single entry: a held beat can be replaced in the same cycle decode takes it.
  assign in_ready = (state_q == ST_EMPTY) | out_ready;
`endif

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
`ifdef IF_ID_SKID_EN
    load_tail = 1'b0;
    shift     = 1'b0;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d   = ST_ONE;
          load_head = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
`ifdef IF_ID_SKID_EN
        end else if (push) begin
          state_d   = ST_FULL;
          load_tail = 1'b1;
`endif
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
`ifdef IF_ID_SKID_EN
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          shift   = 1'b1;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
    // Redirect wins over everything; a same-cycle pop has still been consumed.
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else if (load_head) begin
      head_instr_q <= in_instr;
      head_pc_q    <= in_pc;
`ifdef IF_ID_SKID_EN
    end else if (shift) begin
      head_instr_q <= tail_instr_q;
      head_pc_q    <= tail_pc_q;
`endif
    end
  end

`ifdef IF_ID_SKID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else if (load_tail) begin
      tail_instr_q <= in_instr;
      tail_pc_q    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != ST_FULL);
    end
  end
`endif

  assign out_valid    = (state_q != ST_EMPTY);
  assign out_instr    = out_valid ? head_instr_q : NOP_INSTR;
  assign out_pc       = out_valid ? head_pc_q : '0;
  assign out_misalign = out_valid & (|head_pc_q[1:0]);

endmodule
